// File: rtl/ghost_steer.sv
// Ghost motion steering: turns relative move codes into tile moves, probing a
// 1-cycle-latency wall map and falling back through a fixed candidate order.
module ghost_steer #(
  parameter int MAP_W      = 20,
  parameter int MAP_H      = 15,
  parameter int X_W        = 5,
  parameter int Y_W        = 4,
  parameter int START_X    = 9,
  parameter int START_Y    = 7,
  parameter int START_HEAD = 0
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_step,
  input  logic [3:0]     i_move,
  output logic [X_W-1:0] o_query_x,
  output logic [Y_W-1:0] o_query_y,
  output logic           o_query_valid,
  input  logic           i_wall,
  output logic [X_W-1:0] o_x,
  output logic [Y_W-1:0] o_y,
  output logic [1:0]     o_heading,
  output logic           o_busy,
  output logic           o_moved,
  output logic           o_stuck
);

  typedef enum logic [1:0] {S_IDLE, S_QUERY, S_WAIT} state_t;

  state_t         state, state_n;
  logic [1:0]     turn_q, turn_n;
  logic [1:0]     idx_q, idx_n;
  logic [1:0]     qhead_q;
  logic           load_q, do_move, moved_n, stuck_n;
  logic [1:0]     cand_head;
  logic           cand_ok;
  logic [X_W-1:0] cand_x;
  logic [Y_W-1:0] cand_y;

  // Turns are heading offsets: 0 straight, 1 right, 3 left, 2 reverse.
  function automatic logic [1:0] decode_move(input logic [3:0] mv);
    case (mv)
      4'd1:    return 2'd3;
      4'd3:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] cand_offset(input logic [1:0] turn, input logic [1:0] idx);
    case (idx)
      2'd0:    return turn;
      2'd1:    return (turn == 2'd0) ? 2'd1 : 2'd0;
      2'd2:    return (turn == 2'd3) ? 2'd1 : 2'd3;
      default: return 2'd2;
    endcase
  endfunction

  always_comb begin
    state_n = state;
    turn_n  = turn_q;
    idx_n   = idx_q;
    load_q  = 1'b0;
    do_move = 1'b0;
    moved_n = 1'b0;
    stuck_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_step) begin
          turn_n  = decode_move(i_move);
          idx_n   = 2'd0;
          load_q  = 1'b1;
          state_n = S_QUERY;
        end
      end
      S_QUERY: begin
        // o_query_valid doubles as the "current candidate is in range" flag.
        if (o_query_valid) begin
          state_n = S_WAIT;
        end else if (idx_q == 2'd3) begin
          stuck_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          idx_n  = idx_q + 2'd1;
          load_q = 1'b1;
        end
      end
      S_WAIT: begin
        if (!i_wall) begin
          do_move = 1'b1;
          moved_n = 1'b1;
          state_n = S_IDLE;
        end else if (idx_q == 2'd3) begin
          stuck_n = 1'b1;
          state_n = S_IDLE;
        end else begin
          idx_n   = idx_q + 2'd1;
          load_q  = 1'b1;
          state_n = S_QUERY;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Target of the candidate about to be presented, so the query is registered.
  always_comb begin
    cand_head = o_heading + cand_offset(turn_n, idx_n);
    cand_ok   = 1'b1;
    cand_x    = o_x;
    cand_y    = o_y;
    case (cand_head)
      2'd0: begin
        cand_ok = (o_y != '0);
        cand_y  = o_y - Y_W'(1);
      end
      2'd1: cand_x = (o_x == X_W'(MAP_W - 1)) ? '0 : o_x + X_W'(1);
      2'd2: begin
        cand_ok = (o_y != Y_W'(MAP_H - 1));
        cand_y  = o_y + Y_W'(1);
      end
      default: cand_x = (o_x == '0) ? X_W'(MAP_W - 1) : o_x - X_W'(1);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      turn_q        <= '0;
      idx_q         <= '0;
      qhead_q       <= '0;
      o_query_x     <= '0;
      o_query_y     <= '0;
      o_query_valid <= 1'b0;
      o_x           <= X_W'(START_X);
      o_y           <= Y_W'(START_Y);
      o_heading     <= 2'(START_HEAD);
      o_moved       <= 1'b0;
      o_stuck       <= 1'b0;
    end else begin
      state         <= state_n;
      turn_q        <= turn_n;
      idx_q         <= idx_n;
      o_moved       <= moved_n;
      o_stuck       <= stuck_n;
      o_query_valid <= load_q && cand_ok;
      if (load_q) begin
        qhead_q <= cand_head;
        if (cand_ok) begin
          o_query_x <= cand_x;
          o_query_y <= cand_y;
        end
      end
      if (do_move) begin
        o_x       <= o_query_x;
        o_y       <= o_query_y;
        o_heading <= qhead_q;
      end
    end
  end

  assign o_busy = (state != S_IDLE);

endmodule

// File: tb/tb_ghost_steer.sv
// Directed bench for ghost_steer with a small wall-map memory model.
module tb_ghost_steer;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b1;
  logic       i_step = 1'b0;
  logic [3:0] i_move = 4'd0;
  logic       i_wall;
  logic [4:0] o_query_x, o_x;
  logic [3:0] o_query_y, o_y;
  logic       o_query_valid, o_busy, o_moved, o_stuck;
  logic [1:0] o_heading;

  int vecs = 0;
  int errs = 0;

  logic       blocked [0:19][0:14];
  logic       last_qv = 1'b0;
  logic [4:0] last_qx = '0;
  logic [3:0] last_qy = '0;

  ghost_steer #(.MAP_W(20), .MAP_H(15), .X_W(5), .Y_W(4),
                .START_X(9), .START_Y(7), .START_HEAD(0)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_step(i_step), .i_move(i_move),
    .o_query_x(o_query_x), .o_query_y(o_query_y), .o_query_valid(o_query_valid),
    .i_wall(i_wall), .o_x(o_x), .o_y(o_y), .o_heading(o_heading),
    .o_busy(o_busy), .o_moved(o_moved), .o_stuck(o_stuck)
  );

  always #5 i_clk = ~i_clk;

  // Wall memory: answers one cycle after the query strobe.
  always @(posedge i_clk) begin
    last_qv <= o_query_valid;
    last_qx <= o_query_x;
    last_qy <= o_query_y;
  end
  assign i_wall = last_qv ? blocked[last_qx][last_qy] : 1'b0;

  task automatic clear_walls();
    for (int x = 0; x < 20; x++)
      for (int y = 0; y < 15; y++)
        blocked[x][y] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge i_clk);
    i_step  = 1'b0;
    #2 i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_walls();
  endtask

  // Accept a step at cycle 0; returns at the sampling point of cycle 1.
  task automatic start_step(input logic [3:0] mv);
    @(negedge i_clk);
    i_step = 1'b1;
    i_move = mv;
    @(negedge i_clk);
    i_step = 1'b0;
  endtask

  task automatic nav(input logic [3:0] mv);
    int c;
    start_step(mv);
    c = 1;
    while (!(o_moved || o_stuck) && c < 20) begin
      @(negedge i_clk);
      c++;
    end
    vecs++;
    if (!(o_moved || o_stuck)) begin
      errs++;
      $display("FAIL nav_timeout: got no completion after %0d cycles, want completion within 9", c);
    end
  endtask

  task automatic test_reset();
    #2 i_rst_n = 1'b0;
    #1;
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck, o_query_valid, o_query_x, o_query_y} !==
        {5'd9, 4'd7, 2'd0, 4'b0000, 5'd0, 4'd0}) begin
      errs++;
      $display("FAIL reset_initial: got %h want %h",
               {o_x, o_y, o_heading, o_busy, o_moved, o_stuck, o_query_valid, o_query_x, o_query_y},
               {5'd9, 4'd7, 2'd0, 4'b0000, 5'd0, 4'd0});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    clear_walls();
    nav(4'd2);
    #3 i_rst_n = 1'b0;
    #1;
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck, o_query_valid} !== {5'd9, 4'd7, 2'd0, 4'b0000}) begin
      errs++;
      $display("FAIL reset_midcycle: got %h want %h",
               {o_x, o_y, o_heading, o_busy, o_moved, o_stuck, o_query_valid}, {5'd9, 4'd7, 2'd0, 4'b0000});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    start_step(4'd2);
    @(negedge i_clk);
    vecs++;
    if ({o_busy, o_query_valid} !== 2'b10) begin
      errs++;
      $display("FAIL reset_wait_state: got %b want 10", {o_busy, o_query_valid});
    end
    #2 i_rst_n = 1'b0;
    #1;
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck, o_query_valid} !== {5'd9, 4'd7, 2'd0, 4'b0000}) begin
      errs++;
      $display("FAIL reset_in_wait: got %h want %h",
               {o_x, o_y, o_heading, o_busy, o_moved, o_stuck, o_query_valid}, {5'd9, 4'd7, 2'd0, 4'b0000});
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    begin
      int moves = 0;
      repeat (6) begin
        @(negedge i_clk);
        if (o_moved || o_busy) moves++;
      end
      vecs++;
      if (moves !== 0 || o_y !== 4'd7) begin
        errs++;
        $display("FAIL reset_abort: got activity %0d y %0d want activity 0 y 7", moves, o_y);
      end
    end
  endtask

  task automatic test_open_straight();
    apply_reset();
    start_step(4'd2);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y, o_busy} !== {1'b1, 5'd9, 4'd6, 1'b1}) begin
      errs++;
      $display("FAIL straight_query: got %h want %h", {o_query_valid, o_query_x, o_query_y, o_busy},
               {1'b1, 5'd9, 4'd6, 1'b1});
    end
    @(negedge i_clk);
    @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck} !== {5'd9, 4'd6, 2'd0, 3'b010}) begin
      errs++;
      $display("FAIL straight_move: got %h want %h", {o_x, o_y, o_heading, o_busy, o_moved, o_stuck},
               {5'd9, 4'd6, 2'd0, 3'b010});
    end
    @(negedge i_clk);
    vecs++;
    if (o_moved !== 1'b0) begin
      errs++;
      $display("FAIL straight_pulse: got moved %b want 0", o_moved);
    end
  endtask

  task automatic test_fallback();
    apply_reset();
    blocked[8][7] = 1'b1;
    start_step(4'd1);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y} !== {1'b1, 5'd8, 4'd7}) begin
      errs++;
      $display("FAIL fallback_q0: got %h want %h", {o_query_valid, o_query_x, o_query_y}, {1'b1, 5'd8, 4'd7});
    end
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y} !== {1'b1, 5'd9, 4'd6}) begin
      errs++;
      $display("FAIL fallback_q1: got %h want %h", {o_query_valid, o_query_x, o_query_y}, {1'b1, 5'd9, 4'd6});
    end
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck} !== {5'd9, 4'd6, 2'd0, 3'b010}) begin
      errs++;
      $display("FAIL fallback_move: got %h want %h", {o_x, o_y, o_heading, o_busy, o_moved, o_stuck},
               {5'd9, 4'd6, 2'd0, 3'b010});
    end
  endtask

  task automatic test_dead_end_and_stuck();
    apply_reset();
    blocked[10][7] = 1'b1;
    blocked[9][6]  = 1'b1;
    blocked[8][7]  = 1'b1;
    start_step(4'd3);
    repeat (6) @(negedge i_clk);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y} !== {1'b1, 5'd9, 4'd8}) begin
      errs++;
      $display("FAIL deadend_q3: got %h want %h", {o_query_valid, o_query_x, o_query_y}, {1'b1, 5'd9, 4'd8});
    end
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck} !== {5'd9, 4'd8, 2'd2, 3'b010}) begin
      errs++;
      $display("FAIL deadend_move: got %h want %h", {o_x, o_y, o_heading, o_busy, o_moved, o_stuck},
               {5'd9, 4'd8, 2'd2, 3'b010});
    end
    apply_reset();
    blocked[10][7] = 1'b1;
    blocked[9][6]  = 1'b1;
    blocked[8][7]  = 1'b1;
    blocked[9][8]  = 1'b1;
    start_step(4'd3);
    repeat (7) @(negedge i_clk);
    vecs++;
    if ({o_busy, o_moved, o_stuck} !== 3'b100) begin
      errs++;
      $display("FAIL stuck_early: got %b want 100", {o_busy, o_moved, o_stuck});
    end
    @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck} !== {5'd9, 4'd7, 2'd0, 3'b001}) begin
      errs++;
      $display("FAIL stuck_pulse: got %h want %h", {o_x, o_y, o_heading, o_busy, o_moved, o_stuck},
               {5'd9, 4'd7, 2'd0, 3'b001});
    end
    @(negedge i_clk);
    vecs++;
    if (o_stuck !== 1'b0) begin
      errs++;
      $display("FAIL stuck_width: got stuck %b want 0", o_stuck);
    end
  endtask

  task automatic test_tunnel();
    apply_reset();
    nav(4'd1);
    repeat (8) nav(4'd2);
    vecs++;
    if ({o_x, o_y, o_heading} !== {5'd0, 4'd7, 2'd3}) begin
      errs++;
      $display("FAIL tunnel_setup: got %h want %h", {o_x, o_y, o_heading}, {5'd0, 4'd7, 2'd3});
    end
    start_step(4'd2);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y} !== {1'b1, 5'd19, 4'd7}) begin
      errs++;
      $display("FAIL tunnel_left_query: got %h want %h", {o_query_valid, o_query_x, o_query_y},
               {1'b1, 5'd19, 4'd7});
    end
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_moved} !== {5'd19, 4'd7, 2'd3, 1'b1}) begin
      errs++;
      $display("FAIL tunnel_left_move: got %h want %h", {o_x, o_y, o_heading, o_moved}, {5'd19, 4'd7, 2'd3, 1'b1});
    end
    blocked[18][7] = 1'b1;
    blocked[19][6] = 1'b1;
    blocked[19][8] = 1'b1;
    start_step(4'd2);
    repeat (6) @(negedge i_clk);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y} !== {1'b1, 5'd0, 4'd7}) begin
      errs++;
      $display("FAIL tunnel_right_query: got %h want %h", {o_query_valid, o_query_x, o_query_y},
               {1'b1, 5'd0, 4'd7});
    end
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_moved} !== {5'd0, 4'd7, 2'd1, 1'b1}) begin
      errs++;
      $display("FAIL tunnel_right_move: got %h want %h", {o_x, o_y, o_heading, o_moved}, {5'd0, 4'd7, 2'd1, 1'b1});
    end
  endtask

  task automatic test_vertical_edge();
    apply_reset();
    nav(4'd1);
    repeat (3) nav(4'd2);
    nav(4'd3);
    repeat (6) nav(4'd2);
    vecs++;
    if ({o_x, o_y, o_heading} !== {5'd5, 4'd0, 2'd0}) begin
      errs++;
      $display("FAIL edge_setup: got %h want %h", {o_x, o_y, o_heading}, {5'd5, 4'd0, 2'd0});
    end
    start_step(4'd2);
    vecs++;
    if ({o_busy, o_query_valid} !== 2'b10) begin
      errs++;
      $display("FAIL edge_skip: got %b want 10", {o_busy, o_query_valid});
    end
    @(negedge i_clk);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y} !== {1'b1, 5'd6, 4'd0}) begin
      errs++;
      $display("FAIL edge_query: got %h want %h", {o_query_valid, o_query_x, o_query_y}, {1'b1, 5'd6, 4'd0});
    end
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck} !== {5'd6, 4'd0, 2'd1, 3'b010}) begin
      errs++;
      $display("FAIL edge_move: got %h want %h", {o_x, o_y, o_heading, o_busy, o_moved, o_stuck},
               {5'd6, 4'd0, 2'd1, 3'b010});
    end
  endtask

  task automatic test_decode_ignore();
    int moves;
    apply_reset();
    start_step(4'd7);
    vecs++;
    if ({o_query_valid, o_query_x, o_query_y} !== {1'b1, 5'd9, 4'd6}) begin
      errs++;
      $display("FAIL decode_query: got %h want %h", {o_query_valid, o_query_x, o_query_y}, {1'b1, 5'd9, 4'd6});
    end
    i_step = 1'b1;
    i_move = 4'd1;
    @(negedge i_clk);
    i_step = 1'b0;
    moves = 0;
    repeat (8) begin
      @(negedge i_clk);
      if (o_moved) moves++;
    end
    vecs++;
    if (moves !== 1 || {o_x, o_y, o_heading, o_busy} !== {5'd9, 4'd6, 2'd0, 1'b0}) begin
      errs++;
      $display("FAIL ignore_step: got moves %0d pos %h want moves 1 pos %h", moves,
               {o_x, o_y, o_heading, o_busy}, {5'd9, 4'd6, 2'd0, 1'b0});
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    start_step(4'd2);
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_y, o_moved} !== {4'd6, 1'b1}) begin
      errs++;
      $display("FAIL b2b_first: got %h want %h", {o_y, o_moved}, {4'd6, 1'b1});
    end
    i_step = 1'b1;
    i_move = 4'd2;
    @(negedge i_clk);
    i_step = 1'b0;
    vecs++;
    if ({o_busy, o_moved, o_query_valid, o_query_x, o_query_y} !== {3'b101, 5'd9, 4'd5}) begin
      errs++;
      $display("FAIL b2b_accept: got %h want %h", {o_busy, o_moved, o_query_valid, o_query_x, o_query_y},
               {3'b101, 5'd9, 4'd5});
    end
    repeat (2) @(negedge i_clk);
    vecs++;
    if ({o_x, o_y, o_heading, o_busy, o_moved, o_stuck} !== {5'd9, 4'd5, 2'd0, 3'b010}) begin
      errs++;
      $display("FAIL b2b_second: got %h want %h", {o_x, o_y, o_heading, o_busy, o_moved, o_stuck},
               {5'd9, 4'd5, 2'd0, 3'b010});
    end
  endtask

  initial begin
    clear_walls();
    test_reset();
    test_open_straight();
    test_fallback();
    test_dead_end_and_stuck();
    test_tunnel();
    test_vertical_edge();
    test_decode_ignore();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
